// File: rtl/saturn_jump_unit.sv
// Saturn jump unit: collects GOTO/GOSUB/GOVLNG/GOSBVL operand nibbles and issues a PC load.
// Define SATURN_JUMP_RSTK_EN to add the 8-entry internal return stack (i_rtn / o_rstk_top).
module saturn_jump_unit #(
  parameter int         MAX_NIBBLES     = 5,
  parameter logic [3:0] INSTR_TYPE_JUMP = 4'd4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [3:0]  i_phases,
  input  logic        i_bus_busy,
  input  logic [3:0]  i_nibble,
  input  logic [19:0] i_current_pc,
  input  logic [3:0]  i_instr_type,
  input  logic        i_instr_execute,
  input  logic [2:0]  i_jump_length,
  input  logic [1:0]  i_jump_mode,
  input  logic        i_push_pc,
  output logic [19:0] o_target_pc,
  output logic        o_load_pc,
  output logic        o_push_valid,
  output logic [19:0] o_push_addr,
  output logic        o_busy,
  output logic        o_error
`ifdef SATURN_JUMP_RSTK_EN
  ,
  output logic [19:0] o_rstk_top,
  input  logic        i_rtn
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;

  state_t      state_r;
  logic [2:0]  cnt_r;
  logic [2:0]  len_r;
  logic [1:0]  mode_r;
  logic        push_r;
  logic [19:0] acc_r;
  logic [19:0] field_start_r;

  logic        arm_s;
  logic        bad_s;
  logic [2:0]  n_s;
  logic [4:0]  shamt_s;
  logic [19:0] mask_s;
  logic        sign_s;
  logic [19:0] off_s;
  logic [19:0] push_addr_s;
  logic [19:0] target_s;
  logic        phase_unused_s;

  assign phase_unused_s = &{1'b0, i_phases[1:0]};

  assign arm_s   = i_instr_execute && (i_instr_type == INSTR_TYPE_JUMP);
  assign bad_s   = (({1'b0, i_jump_length} + 4'd1) > 4'(MAX_NIBBLES)) || (i_jump_mode == 2'd3);
  assign n_s     = len_r + 3'd1;
  assign shamt_s = {n_s, 2'b00};
  assign mask_s  = 20'hFFFFF << shamt_s;
  assign sign_s  = acc_r[shamt_s - 5'd1];

  // Target and return-address arithmetic, all modulo 2^20
  always_comb begin
    off_s       = sign_s ? (acc_r | mask_s) : (acc_r & ~mask_s);
    push_addr_s = field_start_r + {17'd0, n_s};
    target_s    = 20'd0;
    case (mode_r)
      2'd0:    target_s = field_start_r + off_s;
      2'd1:    target_s = push_addr_s + off_s;
      2'd2:    target_s = acc_r;
      default: target_s = 20'd0;
    endcase
  end

`ifdef SATURN_JUMP_RSTK_EN
  logic [19:0] rstk_r [8];
  logic        push_now_s;
  logic        pop_now_s;

  assign push_now_s = (state_r == ST_RESOLVE) && i_phases[3] && push_r;
  assign pop_now_s  = (state_r == ST_IDLE) && i_rtn && !arm_s;
  assign o_rstk_top = rstk_r[0];

  // Return stack as a shift register; entry 0 is the top, zeros fill from the bottom
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) rstk_r[i] <= 20'd0;
    end else if (i_clk_en) begin
      if (push_now_s) begin
        for (int i = 7; i > 0; i--) rstk_r[i] <= rstk_r[i-1];
        rstk_r[0] <= push_addr_s;
      end else if (pop_now_s) begin
        for (int i = 0; i < 7; i++) rstk_r[i] <= rstk_r[i+1];
        rstk_r[7] <= 20'd0;
      end
    end
  end
`endif

  // Control FSM with registered pulse/status outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 3'd0;
      len_r         <= 3'd0;
      mode_r        <= 2'd0;
      push_r        <= 1'b0;
      acc_r         <= 20'd0;
      field_start_r <= 20'd0;
      o_target_pc   <= 20'd0;
      o_load_pc     <= 1'b0;
      o_push_valid  <= 1'b0;
      o_push_addr   <= 20'd0;
      o_busy        <= 1'b0;
      o_error       <= 1'b0;
    end else if (i_clk_en) begin
      o_load_pc    <= 1'b0;
      o_push_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (arm_s) begin
            if (bad_s) begin
              o_error <= 1'b1;
            end else begin
              len_r   <= i_jump_length;
              mode_r  <= i_jump_mode;
              push_r  <= i_push_pc;
              cnt_r   <= 3'd0;
              acc_r   <= 20'd0;
              o_busy  <= 1'b1;
              state_r <= ST_COLLECT;
            end
          end
`ifdef SATURN_JUMP_RSTK_EN
          else if (i_rtn) begin
            o_target_pc <= rstk_r[0];
            o_load_pc   <= 1'b1;
          end
`endif
        end
        ST_COLLECT: begin
          if (i_phases[2] && !i_bus_busy) begin
            acc_r[{cnt_r, 2'b00} +: 4] <= i_nibble;
            if (cnt_r == 3'd0) field_start_r <= i_current_pc;
            cnt_r <= cnt_r + 3'd1;
            if (cnt_r == len_r) state_r <= ST_RESOLVE;
          end
        end
        ST_RESOLVE: begin
          if (i_phases[3]) begin
            o_target_pc  <= target_s;
            o_push_addr  <= push_addr_s;
            o_load_pc    <= 1'b1;
            o_push_valid <= push_r;
            o_busy       <= 1'b0;
            state_r      <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_saturn_jump_unit.sv
// Directed bench for saturn_jump_unit: vector table of jump requests plus reset/error/stack sequences.
module tb_saturn_jump_unit;

  localparam logic [3:0] JUMP_T = 4'd4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_clk_en = 1'b0;
  logic [3:0]  i_phases = 4'b0001;
  logic        i_bus_busy = 1'b0;
  logic [3:0]  i_nibble = 4'd0;
  logic [19:0] i_current_pc = 20'd0;
  logic [3:0]  i_instr_type = 4'd0;
  logic        i_instr_execute = 1'b0;
  logic [2:0]  i_jump_length = 3'd0;
  logic [1:0]  i_jump_mode = 2'd0;
  logic        i_push_pc = 1'b0;
  logic [19:0] o_target_pc;
  logic        o_load_pc;
  logic        o_push_valid;
  logic [19:0] o_push_addr;
  logic        o_busy;
  logic        o_error;
`ifdef SATURN_JUMP_RSTK_EN
  logic [19:0] o_rstk_top;
  logic        i_rtn = 1'b0;
`endif

  saturn_jump_unit #(.MAX_NIBBLES(5), .INSTR_TYPE_JUMP(JUMP_T)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_phases(i_phases),
    .i_bus_busy(i_bus_busy), .i_nibble(i_nibble), .i_current_pc(i_current_pc),
    .i_instr_type(i_instr_type), .i_instr_execute(i_instr_execute),
    .i_jump_length(i_jump_length), .i_jump_mode(i_jump_mode), .i_push_pc(i_push_pc),
    .o_target_pc(o_target_pc), .o_load_pc(o_load_pc), .o_push_valid(o_push_valid),
    .o_push_addr(o_push_addr), .o_busy(o_busy), .o_error(o_error)
`ifdef SATURN_JUMP_RSTK_EN
    , .o_rstk_top(o_rstk_top), .i_rtn(i_rtn)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [2:0]  len;
    logic [1:0]  mode;
    logic        push;
    logic [19:0] nibs;
    logic [19:0] pc;
    int          stall;
    logic [19:0] exp_target;
    logic        exp_push;
    logic [19:0] exp_paddr;
  } vec_t;

  vec_t tbl [9];
  int   compared = 0;
  int   mismatched = 0;
  int   ph = 0;

  task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clk_en cycle on the current phase followed by one disabled cycle
  task automatic do_step();
    i_phases = 4'b0001 << ph;
    i_clk_en = 1'b1;
    @(posedge i_clk); #1;
    i_clk_en = 1'b0;
    @(posedge i_clk); #1;
    ph = (ph + 1) % 4;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int k = 0;
    int loads = 0;
    bit stalled = 1'b0;
    bit cap;
    bit prev_last = 1'b0;
    bit lat_ok = 1'b0;
    int cur_ph;
    logic [19:0] got_t = 20'd0;
    logic [19:0] got_a = 20'd0;
    logic        got_p = 1'b0;
    i_instr_execute = 1'b1; i_instr_type = JUMP_T;
    i_jump_length = v.len; i_jump_mode = v.mode; i_push_pc = v.push;
    do_step();
    chk({tag, " busy_after_arm"}, 20'(o_busy), 20'd1);
    for (int s = 0; s < 40 && loads == 0; s++) begin
      cur_ph = ph;
      cap = 1'b0;
      i_bus_busy = 1'b0; i_nibble = 4'h7; i_current_pc = 20'hABCDE;
      if (ph == 2 && k <= int'(v.len)) begin
        if (v.stall == k && !stalled) begin
          i_bus_busy = 1'b1; i_nibble = 4'hA; stalled = 1'b1;
        end else begin
          i_nibble = v.nibs[4*k +: 4]; i_current_pc = v.pc + 20'(k); cap = 1'b1;
        end
      end
      // Spurious re-arm attempts while busy must be ignored
      i_instr_execute = (ph != 2);
      i_jump_length = 3'd0; i_jump_mode = 2'd2; i_push_pc = 1'b1;
      do_step();
      if (cap) k++;
      if (o_load_pc) begin
        loads++; got_t = o_target_pc; got_a = o_push_addr; got_p = o_push_valid;
        lat_ok = (cur_ph == 3) && prev_last;
      end
      prev_last = cap && (k == int'(v.len) + 1);
    end
    i_instr_execute = 1'b0; i_bus_busy = 1'b0;
    chk({tag, " load_count"}, 20'(loads), 20'd1);
    chk({tag, " latency"}, 20'(lat_ok), 20'd1);
    chk({tag, " target"}, got_t, v.exp_target);
    chk({tag, " push_valid"}, 20'(got_p), 20'(v.exp_push));
    chk({tag, " push_addr"}, got_a, v.exp_paddr);
    do_step();
    chk({tag, " load_cleared"}, 20'(o_load_pc), 20'd0);
    chk({tag, " busy_cleared"}, 20'(o_busy), 20'd0);
    chk({tag, " target_hold"}, o_target_pc, v.exp_target);
  endtask

  // Present nibbles on every phase for n steps and count load pulses (expected none)
  task automatic idle_steps(input int n, input string tag);
    int loads = 0;
    for (int s = 0; s < n; s++) begin
      i_nibble = 4'(s); i_current_pc = 20'(s);
      do_step();
      if (o_load_pc) loads++;
    end
    chk({tag, " no_load"}, 20'(loads), 20'd0);
  endtask

  initial begin
    //               len   mode   push  nibs        pc          stall exp_target  push  paddr
    tbl[0] = '{3'd2, 2'd0, 1'b0, 20'h00004, 20'h00101, -1, 20'h00105, 1'b0, 20'h00104};
    tbl[1] = '{3'd2, 2'd0, 1'b0, 20'h00F00, 20'h00010, -1, 20'hFFF10, 1'b0, 20'h00013};
    tbl[2] = '{3'd4, 2'd2, 1'b1, 20'h12345, 20'h00200, -1, 20'h12345, 1'b1, 20'h00205};
    tbl[3] = '{3'd2, 2'd0, 1'b0, 20'h00004, 20'h00101,  1, 20'h00105, 1'b0, 20'h00104};
    tbl[4] = '{3'd2, 2'd1, 1'b1, 20'h00FF3, 20'h01000, -1, 20'h00FF6, 1'b1, 20'h01003};
    tbl[5] = '{3'd2, 2'd1, 1'b0, 20'h00010, 20'h00200, -1, 20'h00213, 1'b0, 20'h00203};
    tbl[6] = '{3'd0, 2'd0, 1'b0, 20'h00008, 20'h00005, -1, 20'hFFFFD, 1'b0, 20'h00006};
    tbl[7] = '{3'd3, 2'd0, 1'b0, 20'h00020, 20'hFFFF0,  2, 20'h00010, 1'b0, 20'hFFFF4};
    tbl[8] = '{3'd4, 2'd2, 1'b1, 20'hFFFFF, 20'h00000, -1, 20'hFFFFF, 1'b1, 20'h00005};

    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("reset target", o_target_pc, 20'd0);
    chk("reset load", 20'(o_load_pc), 20'd0);
    chk("reset push_valid", 20'(o_push_valid), 20'd0);
    chk("reset push_addr", o_push_addr, 20'd0);
    chk("reset busy", 20'(o_busy), 20'd0);
    chk("reset error", 20'(o_error), 20'd0);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of collection, with clk_en low
    i_instr_execute = 1'b1; i_instr_type = JUMP_T;
    i_jump_length = 3'd2; i_jump_mode = 2'd0; i_push_pc = 1'b1;
    do_step();
    i_instr_execute = 1'b0;
    while (ph != 2) do_step();
    i_nibble = 4'h9; i_current_pc = 20'h00300;
    do_step();
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    chk("midreset busy", 20'(o_busy), 20'd0);
    chk("midreset load", 20'(o_load_pc), 20'd0);
    idle_steps(12, "midreset");
    run_vec(tbl[0], "post_reset");

    // Illegal requests: too many nibbles, then mode 3
    i_instr_execute = 1'b1; i_instr_type = JUMP_T;
    i_jump_length = 3'd5; i_jump_mode = 2'd0; i_push_pc = 1'b0;
    do_step();
    i_instr_execute = 1'b0;
    chk("len5 error", 20'(o_error), 20'd1);
    chk("len5 busy", 20'(o_busy), 20'd0);
    idle_steps(8, "len5");
    i_instr_execute = 1'b1; i_jump_length = 3'd2; i_jump_mode = 2'd3;
    do_step();
    i_instr_execute = 1'b0;
    chk("mode3 busy", 20'(o_busy), 20'd0);
    idle_steps(8, "mode3");
    run_vec(tbl[2], "after_err");
    chk("error sticky", 20'(o_error), 20'd1);

`ifdef SATURN_JUMP_RSTK_EN
    begin
      vec_t v;
      for (int i = 1; i <= 9; i++) begin
        v = tbl[2];
        v.pc = 20'(i * 32'h100);
        v.exp_paddr = v.pc + 20'd5;
        run_vec(v, $sformatf("rstk_push%0d", i));
      end
      chk("rstk top", o_rstk_top, 20'h00905);
      for (int j = 0; j < 9; j++) begin
        i_rtn = 1'b1;
        do_step();
        i_rtn = 1'b0;
        chk($sformatf("rstk pop%0d load", j), 20'(o_load_pc), 20'd1);
        chk($sformatf("rstk pop%0d target", j), o_target_pc,
            (j < 8) ? 20'((9 - j) * 32'h100 + 32'd5) : 20'd0);
      end
      chk("rstk empty top", o_rstk_top, 20'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
